// File: rtl/conv_window_buffer.sv
// Sliding-window shift memory exposing the newest SIZE samples as parallel taps to the MAC array.
// Latency: win_data mirrors the shift register directly; win_valid/fill_count update one cycle after the accepted write.
// Backpressure: s_ready is held low while a full window waits to be consumed (or reused), and while clear is high.
// Build option: define CONV_WINDOW_CLR_ZERO_EN to zero the tap memory on reset and clear.

module conv_window_buffer #(
  parameter int WIDTH   = 16,
  parameter int SIZE    = 8,
  parameter int LOGSIZE = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [SIZE-1:0][WIDTH-1:0]   win_data,
  output logic                         win_valid,
  input  logic                         win_ready,
  input  logic                         win_reuse,
  output logic [LOGSIZE:0]             fill_count
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_FULL  = 2'd1,
    ST_STALE = 2'd2
  } state_t;

  localparam logic [LOGSIZE:0] CNT_FULL = (LOGSIZE+1)'(SIZE);
  localparam logic [LOGSIZE:0] CNT_LAST = (LOGSIZE+1)'(SIZE - 1);

  state_t                     state, state_nxt;
  logic [LOGSIZE:0]           count_nxt;
  logic [SIZE-1:0][WIDTH-1:0] mem;
  logic                       wr_en;
  logic                       consume;

  // Taps are the shift register itself, no extra pipeline stage.
  assign win_data = mem;
  assign consume  = win_valid & win_ready;
  assign wr_en    = s_valid & s_ready;

  // Accept a sample unless a held window would be disturbed before it is taken.
  always_comb begin
    s_ready = 1'b1;
    if (clear) begin
      s_ready = 1'b0;
    end else if (state == ST_FULL) begin
      s_ready = win_ready & ~win_reuse;
    end
  end

  // Next state and fill count; clear overrides every other event.
  always_comb begin
    state_nxt = state;
    count_nxt = fill_count;
    if (clear) begin
      state_nxt = ST_FILL;
      count_nxt = '0;
    end else begin
      if (wr_en && fill_count != CNT_FULL) begin
        count_nxt = fill_count + 1'b1;
      end
      unique case (state)
        ST_FILL: begin
          if (wr_en && fill_count == CNT_LAST) begin
            state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          // Reuse keeps the window; a same-cycle write slides it; otherwise wait for data.
          if (consume && !win_reuse && !wr_en) begin
            state_nxt = ST_STALE;
          end
        end
        ST_STALE: begin
          if (wr_en) begin
            state_nxt = ST_FULL;
          end
        end
        default: begin
          state_nxt = ST_FILL;
        end
      endcase
    end
  end

  // Control registers: state, registered win_valid and fill_count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_FILL;
      win_valid  <= 1'b0;
      fill_count <= '0;
    end else begin
      state      <= state_nxt;
      win_valid  <= (state_nxt == ST_FULL);
      fill_count <= count_nxt;
    end
  end

`ifdef CONV_WINDOW_CLR_ZERO_EN
  // Shift register with reset and clear flush so taps read zero when empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem <= '0;
    end else if (clear) begin
      mem <= '0;
    end else if (wr_en) begin
      for (int i = SIZE - 1; i > 0; i--) begin
        mem[i] <= mem[i-1];
      end
      mem[0] <= s_data;
    end
  end
`else
  // Shift register without reset; only win_valid-qualified taps are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = SIZE - 1; i > 0; i--) begin
        mem[i] <= mem[i-1];
      end
      mem[0] <= s_data;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer with hand-computed expectations.
// Inputs are driven 1 time unit after the rising edge; outputs are checked 1 unit later.
// Covers fill, slide, stale, reuse, clear and asynchronous reset mid-fill.

module tb_conv_window_buffer;

  localparam int WIDTH   = 16;
  localparam int SIZE    = 8;
  localparam int LOGSIZE = 3;

  logic                       clk;
  logic                       reset_n;
  logic                       clear;
  logic [WIDTH-1:0]           s_data;
  logic                       s_valid;
  logic                       s_ready;
  logic [SIZE-1:0][WIDTH-1:0] win_data;
  logic                       win_valid;
  logic                       win_ready;
  logic                       win_reuse;
  logic [LOGSIZE:0]           fill_count;

  int vec_cnt = 0;
  int err_cnt = 0;
  int consumes;

  conv_window_buffer #(
    .WIDTH   (WIDTH),
    .SIZE    (SIZE),
    .LOGSIZE (LOGSIZE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .win_data   (win_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_reuse  (win_reuse),
    .fill_count (fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push base+1 .. base+n with s_valid held, checking the count after each.
  task automatic push_run(input int base, input int n);
    for (int k = 1; k <= n; k++) begin
      s_valid = 1'b1;
      s_data  = WIDTH'(base + k);
      #1;
      chk("fill_s_ready", 32'(s_ready), 32'd1);
      step();
      chk("fill_count", 32'(fill_count), 32'(k));
      chk("fill_win_valid", 32'(win_valid), (k == SIZE) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    s_data    = '0;
    s_valid   = 1'b0;
    win_ready = 1'b0;
    win_reuse = 1'b0;
    #22;
    reset_n = 1'b1;
    step();

    // Reset state
    chk("rst_fill_count", 32'(fill_count), 32'd0);
    chk("rst_win_valid", 32'(win_valid), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);

    // Fill with 1..8
    push_run(0, SIZE);
    chk("fill_tap0", 32'(win_data[0]), 32'd8);
    chk("fill_tap7", 32'(win_data[7]), 32'd1);
    s_data = 16'd99;
    #1;
    chk("full_s_ready", 32'(s_ready), 32'd0);
    step();
    chk("hold_tap0", 32'(win_data[0]), 32'd8);
    chk("hold_count", 32'(fill_count), 32'd8);
    chk("hold_win_valid", 32'(win_valid), 32'd1);

    // Slide with 9,10,11
    win_ready = 1'b1;
    for (int d = 9; d <= 11; d++) begin
      s_data = WIDTH'(d);
      #1;
      chk("slide_consume", 32'(win_valid & win_ready), 32'd1);
      chk("slide_s_ready", 32'(s_ready), 32'd1);
      step();
      chk("slide_win_valid", 32'(win_valid), 32'd1);
      chk("slide_tap0", 32'(win_data[0]), 32'(d));
    end
    for (int i = 0; i < SIZE; i++) begin
      chk("slide_taps", 32'(win_data[i]), 32'(11 - i));
    end

    // Stale: consume with no data
    s_valid = 1'b0;
    step();
    win_ready = 1'b0;
    #1;
    chk("stale_win_valid", 32'(win_valid), 32'd0);
    chk("stale_count", 32'(fill_count), 32'd8);
    chk("stale_s_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = 16'd12;
    step();
    s_valid = 1'b0;
    chk("restore_win_valid", 32'(win_valid), 32'd1);
    chk("restore_tap0", 32'(win_data[0]), 32'd12);
    chk("restore_tap1", 32'(win_data[1]), 32'd11);

    // Reuse for 4 cycles; window is 12..5
    win_ready = 1'b1;
    win_reuse = 1'b1;
    s_valid   = 1'b1;
    s_data    = 16'd77;
    consumes  = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("reuse_s_ready", 32'(s_ready), 32'd0);
      if (win_valid && win_ready) consumes++;
      step();
      chk("reuse_tap0", 32'(win_data[0]), 32'd12);
      chk("reuse_tap7", 32'(win_data[7]), 32'd5);
      chk("reuse_count", 32'(fill_count), 32'd8);
    end
    chk("reuse_consumes", 32'(consumes), 32'd4);
    win_reuse = 1'b0;
    win_ready = 1'b0;
    s_valid   = 1'b0;

    // Clear with simultaneous write and consume
    clear     = 1'b1;
    s_valid   = 1'b1;
    s_data    = 16'd55;
    win_ready = 1'b1;
    #1;
    chk("clear_s_ready", 32'(s_ready), 32'd0);
    step();
    clear     = 1'b0;
    s_valid   = 1'b0;
    win_ready = 1'b0;
    chk("clear_count", 32'(fill_count), 32'd0);
    chk("clear_win_valid", 32'(win_valid), 32'd0);
`ifdef CONV_WINDOW_CLR_ZERO_EN
    for (int i = 0; i < SIZE; i++) begin
      chk("clear_tap_zero", 32'(win_data[i]), 32'd0);
    end
`else
    chk("clear_tap0_kept", 32'(win_data[0]), 32'd12);
`endif

    // Fill to 5 then asynchronous reset mid-cycle
    push_run(20, 5);
    s_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_count", 32'(fill_count), 32'd0);
    chk("arst_win_valid", 32'(win_valid), 32'd0);
    #2;
    reset_n = 1'b1;
    step();
    chk("arst_s_ready", 32'(s_ready), 32'd1);
    chk("arst_count_hold", 32'(fill_count), 32'd0);
    push_run(30, SIZE);
    s_valid = 1'b0;
    chk("refill_tap0", 32'(win_data[0]), 32'd38);
    chk("refill_tap7", 32'(win_data[7]), 32'd31);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
